ysyx_23060191_wbu: RTL

Write-back unit for the NPC core: the writer side of the GPR register file. It accepts completed results from the EXU (ALU results) and the LSU (load data) over valid/ready handshakes. Load data is byte-selected and sign/zero-extended, and results are queued in a small in-order FIFO. The unit drives the GPR write port (`wr_en_Rd`/`addr_Rd`/`data_Rd`) with at most one write per cycle, and gives the IDU a pending-write hazard check.

---
 rtl/ysyx_23060191_wbu_if.sv | 34 +++
 rtl/ysyx_23060191_wbu.sv | 128 ++++++++++++
 2 files changed

// File: rtl/ysyx_23060191_wbu_if.sv
// rtl/ysyx_23060191_wbu_if.sv - EXU/LSU result handshake channels into the write-back unit
`ifndef CPU_WIDTH
`define CPU_WIDTH 32
`endif

interface ysyx_23060191_wbu_if;
  logic                  exu_vld;
  logic                  exu_rdy;
  logic                  exu_wen;
  logic [4:0]            exu_rd;
  logic [`CPU_WIDTH-1:0] exu_data;
  logic [`CPU_WIDTH-1:0] exu_pc;

  logic                  lsu_vld;
  logic                  lsu_rdy;
  logic                  lsu_wen;
  logic [4:0]            lsu_rd;
  logic [`CPU_WIDTH-1:0] lsu_rdata;
  logic [2:0]            lsu_funct3;
  logic [1:0]            lsu_addr_lo;
  logic [`CPU_WIDTH-1:0] lsu_pc;

  modport master (
    output exu_vld, exu_wen, exu_rd, exu_data, exu_pc,
    output lsu_vld, lsu_wen, lsu_rd, lsu_rdata, lsu_funct3, lsu_addr_lo, lsu_pc,
    input  exu_rdy, lsu_rdy
  );

  modport slave (
    input  exu_vld, exu_wen, exu_rd, exu_data, exu_pc,
    input  lsu_vld, lsu_wen, lsu_rd, lsu_rdata, lsu_funct3, lsu_addr_lo, lsu_pc,
    output exu_rdy, lsu_rdy
  );
endinterface

// File: rtl/ysyx_23060191_wbu.sv
// rtl/ysyx_23060191_wbu.sv - in-order write-back FIFO driving the GPR write port with load extension and hazard check
// Optional YSYX_23060191_WBU_COMMIT_EN adds commit_vld/commit_pc and stores the PC per entry.
`ifndef CPU_WIDTH
`define CPU_WIDTH 32
`endif

module ysyx_23060191_wbu #(
  parameter int DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  ysyx_23060191_wbu_if.slave    wb,
  input  logic [4:0]            chk_rs1,
  input  logic [4:0]            chk_rs2,
  output logic                  hazard,
  output logic                  wr_en_Rd,
  output logic [4:0]            addr_Rd,
  output logic [`CPU_WIDTH-1:0] data_Rd,
  output logic                  idle
`ifdef YSYX_23060191_WBU_COMMIT_EN
  ,
  output logic                  commit_vld,
  output logic [`CPU_WIDTH-1:0] commit_pc
`endif
);
  localparam int W  = `CPU_WIDTH;
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [CW-1:0] count;
  logic [CW-1:0] free;
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [PW-1:0] tail_e;
  logic [PW-1:0] off;
  logic          pop;
  logic          push_l;
  logic          push_e;

  logic          mem_wen  [DEPTH];
  logic [4:0]    mem_rd   [DEPTH];
  logic [W-1:0]  mem_data [DEPTH];
`ifdef YSYX_23060191_WBU_COMMIT_EN
  logic [W-1:0]  mem_pc   [DEPTH];
`else
  logic          unused_pc;
  assign unused_pc = ^{wb.exu_pc, wb.lsu_pc};
`endif

  logic [7:0]    lbyte;
  logic [15:0]   lhalf;
  logic [W-1:0]  load_ext;

  // Free space counts only the registered occupancy; a same-cycle pop gives no credit.
  assign free       = CW'(DEPTH) - count;
  assign wb.lsu_rdy = (free != '0);
  assign wb.exu_rdy = (free >= CW'(2)) || ((free == CW'(1)) && !wb.lsu_vld);

  assign push_l = wb.lsu_vld && wb.lsu_rdy;
  assign push_e = wb.exu_vld && wb.exu_rdy;
  assign pop    = (count != '0);
  assign tail_e = push_l ? tail + PW'(1) : tail;

  always_comb begin
    lbyte = wb.lsu_rdata[{wb.lsu_addr_lo, 3'b000} +: 8];
    lhalf = wb.lsu_addr_lo[1] ? wb.lsu_rdata[31:16] : wb.lsu_rdata[15:0];
    case (wb.lsu_funct3)
      3'b000:  load_ext = {{(W-8){lbyte[7]}}, lbyte};
      3'b100:  load_ext = {{(W-8){1'b0}}, lbyte};
      3'b001:  load_ext = {{(W-16){lhalf[15]}}, lhalf};
      3'b101:  load_ext = {{(W-16){1'b0}}, lhalf};
      default: load_ext = wb.lsu_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      head  <= '0;
      tail  <= '0;
    end else begin
      count <= count + CW'(push_l) + CW'(push_e) - CW'(pop);
      if (pop) head <= head + PW'(1);
      tail <= tail + PW'(push_l) + PW'(push_e);
    end
  end

  // Payload storage needs no reset: every read of it is qualified by count.
  always_ff @(posedge clk) begin
    if (push_l) begin
      mem_wen[tail]  <= wb.lsu_wen;
      mem_rd[tail]   <= wb.lsu_rd;
      mem_data[tail] <= load_ext;
`ifdef YSYX_23060191_WBU_COMMIT_EN
      mem_pc[tail]   <= wb.lsu_pc;
`endif
    end
    if (push_e) begin
      mem_wen[tail_e]  <= wb.exu_wen;
      mem_rd[tail_e]   <= wb.exu_rd;
      mem_data[tail_e] <= wb.exu_data;
`ifdef YSYX_23060191_WBU_COMMIT_EN
      mem_pc[tail_e]   <= wb.exu_pc;
`endif
    end
  end

  always_comb begin
    hazard = 1'b0;
    off    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off = PW'(i) - head;
      if ((CW'(off) < count) && mem_wen[i] && (mem_rd[i] != 5'd0) &&
          ((mem_rd[i] == chk_rs1) || (mem_rd[i] == chk_rs2)))
        hazard = 1'b1;
    end
  end

  assign wr_en_Rd = pop && mem_wen[head] && (mem_rd[head] != 5'd0);
  assign addr_Rd  = pop ? mem_rd[head]   : 5'd0;
  assign data_Rd  = pop ? mem_data[head] : '0;
  assign idle     = !pop;

`ifdef YSYX_23060191_WBU_COMMIT_EN
  assign commit_vld = pop;
  assign commit_pc  = pop ? mem_pc[head] : '0;
`endif
endmodule
